// File: rtl/xt_collapse.sv
// Micro-op collapser: folds expanded call/return micro-op sequences back
// into one macro-instruction record per expansion for trace and retire.
//
// Ports: iw_clk, iw_rst (sync, active-high); iw_valid/iw_pc/iw_instr/iw_flush
// micro-op input; ow_valid/ow_pc/ow_instr/ow_err registered record output.

`ifndef HBIT_ADDR
`define HBIT_ADDR 15
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif
`ifndef HBIT_OPC
`define HBIT_OPC 7
`endif

package xt_pkg;
  localparam int HBIT_ADDR = `HBIT_ADDR;
  localparam int HBIT_DATA = `HBIT_DATA;
  localparam int HBIT_OPC  = `HBIT_OPC;

  typedef logic [HBIT_OPC:0]  opc_t;
  typedef logic [HBIT_ADDR:0] addr_t;
  typedef logic [HBIT_DATA:0] word_t;

  localparam opc_t OPC_NOP      = 8'h00;
  localparam opc_t OPC_SRSUBsi  = 8'h10;
  localparam opc_t OPC_SRADDsi  = 8'h11;
  localparam opc_t OPC_SRMOVAur = 8'h12;
  localparam opc_t OPC_SRSTso   = 8'h13;
  localparam opc_t OPC_SRMOVur  = 8'h14;
  localparam opc_t OPC_SRLDso   = 8'h15;
  localparam opc_t OPC_SRJCCso  = 8'h16;
  localparam opc_t OPC_JCCui    = 8'h20;
  localparam opc_t OPC_BCCsr    = 8'h21;
  localparam opc_t OPC_BALso    = 8'h22;
  localparam opc_t OPC_JSRui    = 8'h30;
  localparam opc_t OPC_BSRsr    = 8'h31;
  localparam opc_t OPC_BSRso    = 8'h32;
  localparam opc_t OPC_RET      = 8'h33;
  localparam opc_t OPC_SETSSP   = 8'h34;

  localparam logic [1:0] SR_LR  = 2'd0;
  localparam logic [1:0] SR_SSP = 2'd1;
  localparam logic [1:0] SR_FL  = 2'd2;
  localparam logic [1:0] SR_PC  = 2'd3;
endpackage

module xt_collapse
  import xt_pkg::*;
(
  input  logic                 iw_clk,
  input  logic                 iw_rst,
  input  logic                 iw_valid,
  input  logic [`HBIT_ADDR:0]  iw_pc,
  input  logic [`HBIT_DATA:0]  iw_instr,
  input  logic                 iw_flush,
  output logic                 ow_valid,
  output logic [`HBIT_ADDR:0]  ow_pc,
  output logic [`HBIT_DATA:0]  ow_instr,
  output logic                 ow_err
);

  typedef enum logic [2:0] {
    IDLE, P1, P2, P3, R1, R2
  } state_t;

  state_t state, state_n;
  addr_t  spc, spc_n;
  logic   v_n, e_n, bad;
  addr_t  pc_n;
  word_t  ins_n;

  opc_t        op;
  logic [15:0] pl;
  assign op = iw_instr[HBIT_DATA -: HBIT_OPC+1];
  assign pl = iw_instr[15:0];

  logic push0, ret0, setssp;
  logic push1, push2, ret1, ret2;
  logic jcc0, bcc0, bal;

  assign push0  = op == OPC_SRSUBsi
               && pl == {SR_SSP, 14'd2};
  assign ret0   = op == OPC_SRADDsi
               && pl == {SR_SSP, 14'd2};
  assign setssp = op == OPC_SRMOVAur
               && pl[15:14] == SR_SSP
               && pl[11:0] == 12'h000;
  assign push1  = op == OPC_SRSTso
               && pl == {SR_SSP, SR_LR, 12'h000};
  assign push2  = op == OPC_SRMOVur
               && pl == {SR_LR, SR_PC, 12'h000};
  assign ret1   = op == OPC_SRLDso
               && pl == {SR_LR, SR_SSP, 12'hFFE};
  assign ret2   = op == OPC_SRJCCso
               && pl == {SR_LR, 4'h0, 10'd1};
  assign jcc0   = op == OPC_JCCui
               && pl[15:12] == 4'h0;
  assign bcc0   = op == OPC_BCCsr
               && pl[11:0] == 12'h000;
  assign bal    = op == OPC_BALso;

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state    <= IDLE;
      spc      <= '0;
      ow_valid <= 1'b0;
      ow_err   <= 1'b0;
      ow_pc    <= '0;
      ow_instr <= '0;
    end else begin
      state    <= state_n;
      spc      <= spc_n;
      ow_valid <= v_n;
      ow_err   <= e_n;
      ow_pc    <= pc_n;
      ow_instr <= ins_n;
    end
  end

  always_comb begin
    state_n = state;
    spc_n   = spc;
    v_n     = 1'b0;
    e_n     = 1'b0;
    pc_n    = ow_pc;
    ins_n   = ow_instr;
    bad     = 1'b0;
    if (iw_flush) begin
      state_n = IDLE;
    end else if (iw_valid) begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            push0: begin
              state_n = P1;
              spc_n   = iw_pc;
            end
            ret0: begin
              state_n = R1;
              spc_n   = iw_pc;
            end
            setssp: begin
              v_n   = 1'b1;
              pc_n  = iw_pc;
              ins_n = {OPC_SETSSP, pl[13:12], 14'b0};
            end
            default: begin
              v_n   = 1'b1;
              pc_n  = iw_pc;
              ins_n = iw_instr;
            end
          endcase
        end
        P1: begin
          if (push1) state_n = P2;
          else bad = 1'b1;
        end
        P2: begin
          if (push2) state_n = P3;
          else bad = 1'b1;
        end
        P3: begin
          state_n = IDLE;
          v_n     = 1'b1;
          pc_n    = spc;
          unique case (1'b1)
            jcc0: ins_n = {OPC_JSRui, 4'h0, pl[11:0]};
            bcc0: ins_n = {OPC_BSRsr, pl[15:12], 12'h000};
            bal:  ins_n = {OPC_BSRso, pl};
            default: bad = 1'b1;
          endcase
        end
        R1: begin
          if (ret1) state_n = R2;
          else bad = 1'b1;
        end
        R2: begin
          if (ret2) begin
            state_n = IDLE;
            v_n     = 1'b1;
            pc_n    = spc;
            ins_n   = {OPC_RET, 16'h0000};
          end else begin
            bad = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
      // a broken sequence reports the offender and swallows it
      if (bad) begin
        state_n = IDLE;
        v_n     = 1'b0;
        e_n     = 1'b1;
        pc_n    = spc;
        ins_n   = iw_instr;
      end
    end
  end

endmodule

// File: doc/xt_collapse.md
XT_COLLAPSE -- requirements
Module: xt_collapse

Interface
REQ-001 SHALL have no parameters; widths come from `HBIT_ADDR, `HBIT_DATA and `HBIT_OPC in src/sizes.vh, and opcodes and SR indices from src/opcodes.vh and src/sr.vh.
REQ-002 SHALL have port iw_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port iw_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port iw_valid, input, 1 bit: a micro-op is presented this cycle.
REQ-005 SHALL have port iw_pc, input, `HBIT_ADDR+1 bits: PC tagged on the micro-op.
REQ-006 SHALL have port iw_instr, input, `HBIT_DATA+1 bits: micro-op word, {opc, 16-bit payload}.
REQ-007 SHALL have port iw_flush, input, 1 bit: abandon any partial sequence.
REQ-008 SHALL have port ow_valid, output, 1 bit: one reconstructed macro-instruction record this cycle.
REQ-009 SHALL have port ow_pc, output, `HBIT_ADDR+1 bits: PC of the first micro-op of the record.
REQ-010 SHALL have port ow_instr, output, `HBIT_DATA+1 bits: reconstructed macro-instruction word.
REQ-011 SHALL have port ow_err, output, 1 bit: a sequence was broken by an unexpected micro-op.

Function
REQ-012 SHALL perform the inverse of stg_xt: consume the micro-op stream and emit one architectural instruction per completed expansion, for trace and retire accounting.
REQ-013 SHALL register all outputs; a record SHALL appear exactly one cycle after its final micro-op is accepted.
REQ-014 SHALL pulse ow_valid and ow_err for one cycle each; both SHALL be 0 in every other cycle.
REQ-015 SHALL accept a micro-op only in a cycle where iw_valid=1 and iw_flush=0; cycles with iw_valid=0 SHALL leave the state unchanged.
REQ-016 SHALL implement the states IDLE, P1, P2, P3, R1 and R2.
REQ-017 In IDLE, SRSUBsi {SSP, imm14=2} SHALL latch iw_pc as the start PC and go to P1, with no output.
REQ-018 In IDLE, SRADDsi {SSP, imm14=2} SHALL latch the start PC and go to R1, with no output.
REQ-019 In IDLE, SRMOVAur {tgt=SSP, src=s} SHALL emit {OPC_SETSSP, s, 14'b0} and stay in IDLE.
REQ-020 In IDLE, any other micro-op SHALL be emitted unchanged with its own PC (pass-through; NOP included).
REQ-021 In P1, SRSTso {SSP, LR, imm12=0} SHALL go to P2.
REQ-022 In P2, SRMOVur {LR, PC, 12'b0} SHALL go to P3.
REQ-023 In P3, JCCui {cc=0000, imm12} SHALL emit {OPC_JSRui, 4'h0, imm12} and go to IDLE.
REQ-024 In P3, BCCsr {dr, cc=0000, 8'b0} SHALL emit {OPC_BSRsr, dr, 4'b0000, 8'b0} and go to IDLE.
REQ-025 In P3, BALso {imm16} SHALL emit {OPC_BSRso, imm16} and go to IDLE.
REQ-026 In R1, SRLDso {LR, SSP, imm12=-2} SHALL go to R2.
REQ-027 In R2, SRJCCso {LR, cc=0000, imm10=1} SHALL emit {OPC_RET, 16'b0} and go to IDLE.
REQ-028 Every emitted sequence record SHALL carry the start PC latched in IDLE on ow_pc.
REQ-029 In P1, P2, P3, R1 or R2, any micro-op other than the expected one, including a JCCui or BCCsr with cc≠0000, SHALL raise ow_err=1 with ow_pc = start PC, ow_instr = the offending micro-op and ow_valid=0; the FSM SHALL return to IDLE and the offending micro-op SHALL be consumed, not re-decoded.
REQ-030 iw_flush=1 SHALL force IDLE in the same edge and discard the input micro-op, with no output and no error; flush SHALL take priority over valid.
REQ-031 Payload fields SHALL compare bit-exact over the whole word, with imm12=-2 meaning 12'hFFE.

Reset
REQ-032 While iw_rst=1 at a clock edge, the FSM SHALL go to IDLE, ow_valid=0, ow_err=0, ow_pc=0, ow_instr=0, and the start PC register SHALL clear to 0.
REQ-033 iw_rst SHALL take priority over iw_flush and iw_valid.
REQ-034 Reset asserted mid-sequence SHALL drop the partial sequence silently.

Verification
REQ-035 SHALL cover: the four JSRui micro-ops at PC 0x10..0x13 with imm12=0xABC -> one cycle after the last, ow_valid=1, ow_pc=0x10, ow_instr={OPC_JSRui,4'h0,12'hABC}; no output on the first three.
REQ-036 SHALL cover: the three RET micro-ops, then idle, then SRMOVAur {SSP,2'b01} -> {OPC_RET,16'b0}, followed by {OPC_SETSSP,2'b01,14'b0}.
REQ-037 SHALL cover: the push prefix followed by BCCsr {dr=3, cc=0000} -> BSRsr with dr=3; the push prefix followed by BALso 0x00F0 -> {OPC_BSRso,16'h00F0}.
REQ-038 SHALL cover: the push prefix followed by JCCui with cc=1010 -> ow_err=1, ow_valid=0, ow_instr = that JCCui; the next JCCui {1010,0x123} passes through unchanged.
REQ-039 SHALL cover: SRSUBsi SSP #2, then iw_flush=1, then SRSTso -> SRSTso passes through, with no error.
REQ-040 SHALL cover: iw_valid=0 gaps inside a RET sequence -> the same RET record is emitted, and reset in R1 -> no output.
